// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types and constants for the register-file write arbiter.
//   XLEN_DEF   default data width
//   REG_ADDR_W register-number width
//   rf_wr_t    one pending register write {live, rd, data}. It is used for the
//              LLU buffer slots and for the registered write-port output.
//   rd_onehot  decodes a register number into a one-hot register mask
package rf_arb_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEF-1:0]   data;
  } rf_wr_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    rd_onehot     = '0;
    rd_onehot[rd] = 1'b1;
  endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// rf_arb_fifo: DEPTH-slot circular buffer for long-latency-unit writes.
// Slots that a younger writeback has overwritten are killed in place. A killed
// slot still occupies its position and still counts toward count. It is later
// dequeued with no write.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push          enqueue push_entry at the write pointer (caller guarantees not full)
//   push_entry    entry to enqueue
//   pop           dequeue the head (caller guarantees not empty)
//   kill_en       clear live on every live slot whose rd equals kill_rd
//   kill_rd       register number being overwritten by writeback
//   head          slot at the read pointer
//   count         occupied slots, killed slots included
//   live_rd       per-slot rd, or 0 when the slot is not live
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  rf_wr_t                              push_entry,
  input  logic                                pop,
  input  logic                                kill_en,
  input  logic [REG_ADDR_W-1:0]               kill_rd,
  output rf_wr_t                              head,
  output logic [$clog2(DEPTH):0]              count,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    live_rd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rf_wr_t [DEPTH-1:0] slot_q,   slot_d;
  logic   [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic   [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic   [CNT_W-1:0] count_q,  count_d;

  // NOTE: every signal gets its default at the top of an always_comb, so no
  // path through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (kill_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_q[i].live && (slot_q[i].rd == kill_rd)) begin
          slot_d[i].live = 1'b0;
        end
      end
    end

    if (pop) begin
      slot_d[rd_ptr_q].live = 1'b0;
      rd_ptr_d              = rd_ptr_q + PTR_W'(1);
    end

    // The caller only pushes when not full. The write slot therefore never
    // holds a live entry, and it is never the slot being popped.
    if (push) begin
      slot_d[wr_ptr_q] = push_entry;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  // NOTE: the slot array is reset along with the pointers. Its live bits must
  // come up clear, and the array is too small to be worth splitting into
  // reset and non-reset storage.
  // NOTE: state is updated with non-blocking assignments, so every flop
  // samples the values it held before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = slot_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    live_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live_rd[i] = slot_q[i].live ? slot_q[i].rd : '0;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file's single write port between the
// writeback stage and a long-latency unit (LLU).
//
// Writeback always wins the port. LLU results wait in rf_arb_fifo and drain
// into idle write-port cycles. A writeback to rd kills any buffered LLU write
// to the same rd, because writeback is always the younger write.
//
// Optional feature, enabled by defining the macro RF_ARB_BYPASS_EN: when the
// buffer is empty and the port is idle, an LLU write goes straight to the
// port. It is then visible one cycle after acceptance.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   wb_valid/wb_rd/wb_data     writeback request, always taken
//   llu_valid/llu_rd/llu_data  LLU request; accepted when llu_valid && llu_ready
//   llu_ready                  buffer not full (registered count only)
//   rf_we/rf_rd/rf_wdata       registered register-file write port
//   pending_mask               one bit per register with a live buffered write
//   fifo_count                 occupied buffer slots, killed slots included
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_valid,
  input  logic [REG_ADDR_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  input  logic                    llu_valid,
  output logic                    llu_ready,
  input  logic [REG_ADDR_W-1:0]   llu_rd,
  input  logic [XLEN-1:0]         llu_data,
  output logic                    rf_we,
  output logic [REG_ADDR_W-1:0]   rf_rd,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [NUM_REGS-1:0]     pending_mask,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                             wb_sel;
  logic                             llu_take;
  logic                             waw_drop;
  logic                             bypass;
  logic                             push;
  logic                             pop;
  rf_wr_t                           head;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] live_rd;
  rf_wr_t                           out_q, out_d;

  assign wb_sel    = wb_valid && (wb_rd != '0);
  assign llu_ready = (fifo_count < CNT_W'(DEPTH));
  // An LLU write to x0 is accepted and then dropped.
  assign llu_take  = llu_valid && llu_ready && (llu_rd != '0);
  // Writeback is younger, so an LLU write to the same rd in the same cycle is dead on arrival.
  assign waw_drop  = wb_sel && (llu_rd == wb_rd);

`ifdef RF_ARB_BYPASS_EN
  assign bypass = !wb_sel && (fifo_count == '0) && llu_take;
`else
  assign bypass = 1'b0;
`endif

  assign push = llu_take && !waw_drop && !bypass;
  assign pop  = !wb_sel && (fifo_count != '0);

  rf_arb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry ('{live: 1'b1, rd: llu_rd, data: llu_data}),
    .pop        (pop),
    .kill_en    (wb_sel),
    .kill_rd    (wb_rd),
    .head       (head),
    .count      (fifo_count),
    .live_rd    (live_rd)
  );

  // Priority select: writeback, then buffer head (a killed head drains
  // silently), then bypass.
  always_comb begin
    out_d = '0;
    if (wb_sel) begin
      out_d = '{live: 1'b1, rd: wb_rd, data: wb_data};
    end else if (pop) begin
      if (head.live) begin
        out_d = head;
      end
    end else if (bypass) begin
      out_d = '{live: 1'b1, rd: llu_rd, data: llu_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign rf_we    = out_q.live;
  assign rf_rd    = out_q.rd;
  assign rf_wdata = out_q.data;

  // A non-live slot reports rd 0. That lands on bit 0, which is forced clear.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_mask = pending_mask | rd_onehot(live_rd[i]);
    end
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed, self-checking bench for rf_write_arbiter.
// The expected values are hand-derived, and the bypass scenario follows
// RF_ARB_BYPASS_EN. Inputs change 1 ns after a rising edge, and outputs are
// sampled at the same point.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        llu_valid;
  logic        llu_ready;
  logic [4:0]  llu_rd;
  logic [31:0] llu_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .XLEN  (32),
    .DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .llu_valid    (llu_valid),
    .llu_ready    (llu_ready),
    .llu_rd       (llu_rd),
    .llu_data     (llu_data),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata),
    .pending_mask (pending_mask),
    .fifo_count   (fifo_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    llu_valid = 1'b0;
    llu_rd    = '0;
    llu_data  = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    check("rst_we",    rf_we,        1'b0);
    check("rst_rd",    rf_rd,        5'd0);
    check("rst_data",  rf_wdata,     32'h0);
    check("rst_count", fifo_count,   3'd0);
    check("rst_ready", llu_ready,    1'b1);
    check("rst_mask",  pending_mask, 32'h0);
    #11 rst = 1'b0;
    step();

    // Plain writeback: visible one cycle later, no pending bits.
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hAAAA0001;
    check("t1_mask_pre", pending_mask, 32'h0);
    step();
    idle();
    check("t1_we",   rf_we,        1'b1);
    check("t1_rd",   rf_rd,        5'd5);
    check("t1_data", rf_wdata,     32'hAAAA0001);
    check("t1_mask", pending_mask, 32'h0);
    step();
    check("t1_we_off", rf_we, 1'b0);

    // Writeback busy for 6 cycles while the LLU offers rd 1..5: the buffer fills at 4.
    for (int k = 1; k <= 6; k++) begin
      wb_valid  = 1'b1; wb_rd = 5'd20; wb_data = 32'h2000 + k;
      llu_valid = 1'b1;
      llu_rd    = (k <= 5) ? 5'(k) : 5'd5;
      llu_data  = 32'h100 + ((k <= 5) ? k : 5);
      check("t2_ready", llu_ready, (k <= 4) ? 1'b1 : 1'b0);
      step();
      check("t2_wb_rd", rf_rd, 5'd20);
    end
    check("t2_count_full", fifo_count,   3'd4);
    check("t2_mask_full",  pending_mask, 32'h0000_001E);
    wb_valid = 1'b0;
    check("t2_full", llu_ready, 1'b0);
    step();
    for (int j = 1; j <= 5; j++) begin
      check("t2_drain_we",   rf_we,    1'b1);
      check("t2_drain_rd",   rf_rd,    5'(j));
      check("t2_drain_data", rf_wdata, 32'h100 + j);
      if (j == 1) check("t2_ready_back", llu_ready, 1'b1);
      if (j == 2) llu_valid = 1'b0;
      step();
    end
    check("t2_drain_done", rf_we,      1'b0);
    check("t2_count_end",  fifo_count, 3'd0);

    // WAW kill: buffered rd7 is killed by the younger writeback to rd7.
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    llu_valid = 1'b1; llu_rd = 5'd7; llu_data = 32'h77;
    step();
    llu_valid = 1'b0;
    wb_rd = 5'd7; wb_data = 32'h11;
    check("t3_mask_set", pending_mask, 32'h0000_0080);
    step();
    idle();
    check("t3_wb_rd",    rf_rd,        5'd7);
    check("t3_wb_data",  rf_wdata,     32'h11);
    check("t3_mask_clr", pending_mask, 32'h0);
    check("t3_count",    fifo_count,   3'd1);
    step();
    check("t3_kill_we",  rf_we,      1'b0);
    check("t3_count0",   fifo_count, 3'd0);
    step();
    check("t3_no_late",  rf_we, 1'b0);

    // Same-cycle WB and LLU to one rd: the LLU write is accepted and dropped.
    wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'hC0DE;
    llu_valid = 1'b1; llu_rd = 5'd12; llu_data = 32'hBAD0;
    step();
    idle();
    check("t4_data",  rf_wdata,   32'hC0DE);
    check("t4_count", fifo_count, 3'd0);
    step();
    check("t4_no_llu", rf_we, 1'b0);

    // x0 from both sources in the same cycle.
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    llu_valid = 1'b1; llu_rd = 5'd0; llu_data = 32'hBEEF;
    step();
    idle();
    check("t5_we",    rf_we,        1'b0);
    check("t5_count", fifo_count,   3'd0);
    check("t5_ready", llu_ready,    1'b1);
    check("t5_mask",  pending_mask, 32'h0);
    step();
    check("t5_we2",   rf_we,        1'b0);

    // Idle-port LLU write: bypassed, or buffered for one cycle.
    llu_valid = 1'b1; llu_rd = 5'd9; llu_data = 32'h55;
    step();
    idle();
`ifdef RF_ARB_BYPASS_EN
    check("t6_we",    rf_we,        1'b1);
    check("t6_rd",    rf_rd,        5'd9);
    check("t6_data",  rf_wdata,     32'h55);
    check("t6_mask",  pending_mask, 32'h0);
    check("t6_count", fifo_count,   3'd0);
`else
    check("t6_we0",   rf_we,        1'b0);
    check("t6_mask",  pending_mask, 32'h0000_0200);
    check("t6_count", fifo_count,   3'd1);
    step();
    check("t6_we",    rf_we,        1'b1);
    check("t6_rd",    rf_rd,        5'd9);
    check("t6_data",  rf_wdata,     32'h55);
    check("t6_mask0", pending_mask, 32'h0);
`endif
    step();
    check("t6_once", rf_we, 1'b0);

    // Three buffered entries flushed by an asynchronous mid-cycle reset.
    for (int k = 10; k <= 12; k++) begin
      wb_valid = 1'b1; wb_rd = 5'd21; wb_data = 32'h21;
      llu_valid = 1'b1; llu_rd = 5'(k); llu_data = 32'h500 + k;
      step();
    end
    llu_valid = 1'b0;
    check("t7_count", fifo_count,   3'd3);
    check("t7_mask",  pending_mask, 32'h0000_1C00);
    #2 rst = 1'b1;
    #1;
    check("t7_rst_we",    rf_we,        1'b0);
    check("t7_rst_rd",    rf_rd,        5'd0);
    check("t7_rst_data",  rf_wdata,     32'h0);
    check("t7_rst_count", fifo_count,   3'd0);
    check("t7_rst_mask",  pending_mask, 32'h0);
    check("t7_rst_ready", llu_ready,    1'b1);
    idle();
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t7_post_we", rf_we, 1'b0);
    end
    check("t7_post_count", fifo_count, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
